fir_tap_loader: RTL and testbench

//  Initiator side of the FIR core tap-write interface (tap_Transfer/tap_Index/tap_Data).

---
 rtl/fir_tap_loader.sv | 173 +++++++++++++++++
 tb/tb_fir_tap_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_loader.sv
// Initiator for the FIR core tap-write port: takes NUM_TAPS coefficients from a valid/ready
// stream and strobes each into the core in index order. Optional macro TAPLOAD_CHECKSUM_EN adds a checksum port.
module fir_tap_loader #(
   parameter int NUM_TAPS    = 16,
   parameter int IDX_W       = 4,
   parameter int DATA_W      = 32,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              areset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              s_tap_valid,
   input  logic [DATA_W-1:0] s_tap_data,
   output logic              s_tap_ready,
   output logic              tap_Transfer,
   output logic [IDX_W-1:0]  tap_Index,
   output logic [DATA_W-1:0] tap_Data,
   output logic              en_FIR,
   output logic              busy,
   output logic              done
`ifdef TAPLOAD_CHECKSUM_EN
  ,output logic [DATA_W-1:0] checksum
`endif
);

   // state  | meaning
   // IDLE   | no load; en_FIR shows whether the last load completed
   // WAIT   | ready for the coefficient of tap idx
   // HOLD   | tap_Transfer high, hold counter running down
   // GAP    | one idle cycle between strobes; terminal index check
   // DONE   | full table written, done pulse, en_FIR raised
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_GAP,
      S_DONE
   } state_t;

   localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TAPS - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
   logic                tap_transfer_q, tap_transfer_d;
   logic [IDX_W-1:0]    tap_index_q, tap_index_d;
   logic [DATA_W-1:0]   tap_data_q, tap_data_d;
   logic                en_fir_q, en_fir_d;
   logic                done_q, done_d;
   logic                accept;
`ifdef TAPLOAD_CHECKSUM_EN
   logic [DATA_W-1:0]   csum_q, csum_d;
`endif

   assign s_tap_ready  = (state_q == S_WAIT) & ~abort;
   assign accept       = s_tap_ready & s_tap_valid;
   assign busy         = (state_q != S_IDLE);
   assign tap_Transfer = tap_transfer_q;
   assign tap_Index    = tap_index_q;
   assign tap_Data     = tap_data_q;
   assign en_FIR       = en_fir_q;
   assign done         = done_q;
`ifdef TAPLOAD_CHECKSUM_EN
   assign checksum     = csum_q;
`endif

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      hcnt_d         = hcnt_q;
      tap_transfer_d = tap_transfer_q;
      tap_index_d    = tap_index_q;
      tap_data_d     = tap_data_q;
      en_fir_d       = en_fir_q;
      done_d         = 1'b0;
`ifdef TAPLOAD_CHECKSUM_EN
      csum_d         = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_WAIT;
               en_fir_d = 1'b0;
               idx_d    = '0;
`ifdef TAPLOAD_CHECKSUM_EN
               csum_d   = '0;
`endif
            end
         end
         S_WAIT: begin
            if (accept) begin
               state_d        = S_HOLD;
               tap_transfer_d = 1'b1;
               tap_index_d    = idx_q;
               tap_data_d     = s_tap_data;
               hcnt_d         = HOLD_LOAD;
`ifdef TAPLOAD_CHECKSUM_EN
               csum_d         = csum_q ^ s_tap_data;
`endif
            end
         end
         S_HOLD: begin
            // Clearing on the way out keeps the strobe exactly HOLD_CYCLES long.
            if (hcnt_q == '0) begin
               state_d        = S_GAP;
               tap_transfer_d = 1'b0;
               tap_index_d    = '0;
               tap_data_d     = '0;
            end else begin
               hcnt_d = hcnt_q - HCNT_W'(1);
            end
         end
         S_GAP: begin
            if (idx_q == LAST_IDX) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               en_fir_d = 1'b1;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A cancelled load leaves the table invalid, so en_FIR is not raised.
      if (abort && (state_q != S_IDLE)) begin
         state_d        = S_IDLE;
         tap_transfer_d = 1'b0;
         tap_index_d    = '0;
         tap_data_d     = '0;
         done_d         = 1'b0;
         en_fir_d       = en_fir_q;
      end
   end

   always_ff @(posedge CLK or negedge areset_n) begin
      if (!areset_n) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         hcnt_q         <= '0;
         tap_transfer_q <= 1'b0;
         tap_index_q    <= '0;
         tap_data_q     <= '0;
         en_fir_q       <= 1'b0;
         done_q         <= 1'b0;
`ifdef TAPLOAD_CHECKSUM_EN
         csum_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         hcnt_q         <= hcnt_d;
         tap_transfer_q <= tap_transfer_d;
         tap_index_q    <= tap_index_d;
         tap_data_q     <= tap_data_d;
         en_fir_q       <= en_fir_d;
         done_q         <= done_d;
`ifdef TAPLOAD_CHECKSUM_EN
         csum_q         <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader (default parameters); checksum scenario runs when
// TAPLOAD_CHECKSUM_EN is defined.
module tb_fir_tap_loader;

   logic        CLK = 1'b0;
   logic        areset_n;
   logic        start;
   logic        abort;
   logic        s_tap_valid;
   logic [31:0] s_tap_data;
   logic        s_tap_ready;
   logic        tap_Transfer;
   logic [3:0]  tap_Index;
   logic [31:0] tap_Data;
   logic        en_FIR;
   logic        busy;
   logic        done;
`ifdef TAPLOAD_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fir_tap_loader dut (
      .CLK          (CLK),
      .areset_n     (areset_n),
      .start        (start),
      .abort        (abort),
      .s_tap_valid  (s_tap_valid),
      .s_tap_data   (s_tap_data),
      .s_tap_ready  (s_tap_ready),
      .tap_Transfer (tap_Transfer),
      .tap_Index    (tap_Index),
      .tap_Data     (tap_Data),
      .en_FIR       (en_FIR),
      .busy         (busy),
      .done         (done)
`ifdef TAPLOAD_CHECKSUM_EN
     ,.checksum     (checksum)
`endif
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drives one beat from a WAIT cycle; leaves the bench one tap later.
   task automatic feed_tap(input logic [31:0] d);
      s_tap_valid = 1'b1;
      s_tap_data  = d;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      areset_n = 1'b0; start = 1'b0; abort = 1'b0; s_tap_valid = 1'b0; s_tap_data = '0;
      #2;
      checks++; if (tap_Transfer !== 1'b0) begin errors++; $display("FAIL reset_xfer: got %b expected 0", tap_Transfer); end
      checks++; if (tap_Index !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", tap_Index); end
      checks++; if (tap_Data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", tap_Data); end
      checks++; if (en_FIR !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en_FIR); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (s_tap_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", s_tap_ready); end
      areset_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
   endtask

   // Timeline from the first WAIT cycle (t=1): per tap accept, 2 strobe cycles, gap; DONE at t=65.
   task automatic test_full_load();
      logic        ex_xfer, ex_done, ex_en, ex_ready, ex_busy;
      logic [3:0]  ex_idx;
      logic [31:0] ex_data;
      int          ph;
      start = 1'b1;
      tick();
      start = 1'b0; s_tap_valid = 1'b1; s_tap_data = 32'hFFFF_FFFF;
      checks++; if (s_tap_ready !== 1'b1) begin errors++; $display("FAIL full_first_ready: got %b expected 1", s_tap_ready); end
      for (int t = 2; t <= 66; t++) begin
         tick();
         ph       = (t - 1) % 4;
         ex_xfer  = (t <= 64) && (ph == 1 || ph == 2);
         ex_idx   = ex_xfer ? 4'((t - 1) / 4) : 4'd0;
         ex_data  = ex_xfer ? 32'hFFFF_FFFF : 32'd0;
         ex_done  = (t == 65);
         ex_en    = (t >= 65);
         ex_ready = (t <= 64) && (ph == 0);
         ex_busy  = (t <= 65);
         checks++; if (tap_Transfer !== ex_xfer) begin errors++; $display("FAIL full_xfer t=%0d: got %b expected %b", t, tap_Transfer, ex_xfer); end
         checks++; if (tap_Index !== ex_idx) begin errors++; $display("FAIL full_index t=%0d: got %0d expected %0d", t, tap_Index, ex_idx); end
         checks++; if (tap_Data !== ex_data) begin errors++; $display("FAIL full_data t=%0d: got %h expected %h", t, tap_Data, ex_data); end
         checks++; if (done !== ex_done) begin errors++; $display("FAIL full_done t=%0d: got %b expected %b", t, done, ex_done); end
         checks++; if (en_FIR !== ex_en) begin errors++; $display("FAIL full_en t=%0d: got %b expected %b", t, en_FIR, ex_en); end
         checks++; if (s_tap_ready !== ex_ready) begin errors++; $display("FAIL full_ready t=%0d: got %b expected %b", t, s_tap_ready, ex_ready); end
         checks++; if (busy !== ex_busy) begin errors++; $display("FAIL full_busy t=%0d: got %b expected %b", t, busy, ex_busy); end
      end
      s_tap_valid = 1'b0;
   endtask

   task automatic test_reset_mid_hold();
      start = 1'b1;
      tick();
      start = 1'b0; s_tap_valid = 1'b1; s_tap_data = 32'h0000_1234;
      tick();
      checks++; if (tap_Transfer !== 1'b1) begin errors++; $display("FAIL rst_hold_pre: xfer got %b expected 1", tap_Transfer); end
      #2 areset_n = 1'b0;
      #1;
      checks++; if (tap_Transfer !== 1'b0) begin errors++; $display("FAIL rst_hold_xfer: got %b expected 0", tap_Transfer); end
      checks++; if (en_FIR !== 1'b0) begin errors++; $display("FAIL rst_hold_en: got %b expected 0", en_FIR); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy: got %b expected 0", busy); end
      checks++; if (s_tap_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_ready: got %b expected 0", s_tap_ready); end
      checks++; if (tap_Data !== 32'd0) begin errors++; $display("FAIL rst_hold_data: got %h expected 0", tap_Data); end
      #2 areset_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_idle: busy got %b expected 0", busy); end
      checks++; if (s_tap_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_noready: got %b expected 0", s_tap_ready); end
      tick();
      checks++; if (tap_Transfer !== 1'b0) begin errors++; $display("FAIL rst_hold_noxfer: got %b expected 0", tap_Transfer); end
      s_tap_valid = 1'b0;
   endtask

   task automatic test_stall();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) feed_tap(32'hC0DE_0000 + 32'(k));
      s_tap_valid = 1'b0; s_tap_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (s_tap_ready !== 1'b1) begin errors++; $display("FAIL stall_ready i=%0d: got %b expected 1", i, s_tap_ready); end
         checks++; if (tap_Transfer !== 1'b0) begin errors++; $display("FAIL stall_xfer i=%0d: got %b expected 0", i, tap_Transfer); end
      end
      s_tap_valid = 1'b1; s_tap_data = 32'hC0DE_0004;
      tick();
      checks++; if (tap_Transfer !== 1'b1) begin errors++; $display("FAIL stall_resume_xfer: got %b expected 1", tap_Transfer); end
      checks++; if (tap_Index !== 4'd4) begin errors++; $display("FAIL stall_resume_index: got %0d expected 4", tap_Index); end
      checks++; if (tap_Data !== 32'hC0DE_0004) begin errors++; $display("FAIL stall_resume_data: got %h expected c0de0004", tap_Data); end
      repeat (3) tick();
      for (int k = 5; k < 16; k++) feed_tap(32'hC0DE_0000 + 32'(k));
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done); end
      checks++; if (en_FIR !== 1'b1) begin errors++; $display("FAIL stall_en: got %b expected 1", en_FIR); end
      s_tap_valid = 1'b0;
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_abort();
      int dcount;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) feed_tap(32'h5A00_0000 + 32'(k));
      s_tap_valid = 1'b1; s_tap_data = 32'h5A00_0005;
      tick();
      checks++; if (tap_Index !== 4'd5) begin errors++; $display("FAIL abort_pre_index: got %0d expected 5", tap_Index); end
      abort = 1'b1;
      tick();
      abort = 1'b0; s_tap_valid = 1'b0;
      checks++; if (tap_Transfer !== 1'b0) begin errors++; $display("FAIL abort_xfer: got %b expected 0", tap_Transfer); end
      checks++; if (tap_Index !== 4'd0) begin errors++; $display("FAIL abort_index: got %0d expected 0", tap_Index); end
      checks++; if (tap_Data !== 32'd0) begin errors++; $display("FAIL abort_data: got %h expected 0", tap_Data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (en_FIR !== 1'b0) begin errors++; $display("FAIL abort_en: got %b expected 0", en_FIR); end
      dcount = 0;
      for (int i = 0; i < 4; i++) begin
         if (done === 1'b1) dcount++;
         tick();
      end
      checks++; if (dcount != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dcount); end
      start = 1'b1;
      tick();
      start = 1'b0; s_tap_valid = 1'b1; s_tap_data = 32'h0BAD_F00D;
      tick();
      checks++; if (tap_Index !== 4'd0 || tap_Transfer !== 1'b1) begin errors++; $display("FAIL abort_restart: index %0d xfer %b expected 0 1", tap_Index, tap_Transfer); end
      checks++; if (tap_Data !== 32'h0BAD_F00D) begin errors++; $display("FAIL abort_restart_data: got %h expected 0badf00d", tap_Data); end
      abort = 1'b1;
      tick();
      abort = 1'b0; s_tap_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int dcount;
      logic ex_xfer;
      logic [3:0] ex_idx;
      start = 1'b1;
      tick();
      start = 1'b0; s_tap_valid = 1'b1; s_tap_data = 32'h0000_7777;
      dcount = 0;
      for (int t = 2; t <= 66; t++) begin
         start = (t == 10 || t == 31);
         tick();
         ex_xfer = (t <= 64) && (((t - 1) % 4 == 1) || ((t - 1) % 4 == 2));
         ex_idx  = ex_xfer ? 4'((t - 1) / 4) : 4'd0;
         if (done === 1'b1) dcount++;
         checks++; if (tap_Transfer !== ex_xfer) begin errors++; $display("FAIL b2b_xfer t=%0d: got %b expected %b", t, tap_Transfer, ex_xfer); end
         checks++; if (tap_Index !== ex_idx) begin errors++; $display("FAIL b2b_index t=%0d: got %0d expected %0d", t, tap_Index, ex_idx); end
      end
      start = 1'b0;
      checks++; if (dcount != 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", dcount); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy got %b expected 0", busy); end
      s_tap_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0; s_tap_valid = 1'b1; s_tap_data = 32'h0000_1111; abort = 1'b1;
      #1;
      checks++; if (s_tap_ready !== 1'b0) begin errors++; $display("FAIL b2b_abort_ready: got %b expected 0", s_tap_ready); end
      tick();
      abort = 1'b0;
      checks++; if (tap_Transfer !== 1'b0) begin errors++; $display("FAIL b2b_abort_xfer: got %b expected 0", tap_Transfer); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_abort_busy: got %b expected 0", busy); end
      checks++; if (en_FIR !== 1'b0) begin errors++; $display("FAIL b2b_abort_en: got %b expected 0", en_FIR); end
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start_wins: busy got %b expected 1", busy); end
      tick();
      checks++; if (tap_Transfer !== 1'b1 || tap_Index !== 4'd0) begin errors++; $display("FAIL b2b_beat_kept: xfer %b index %0d expected 1 0", tap_Transfer, tap_Index); end
      checks++; if (tap_Data !== 32'h0000_1111) begin errors++; $display("FAIL b2b_beat_data: got %h expected 00001111", tap_Data); end
      abort = 1'b1;
      tick();
      abort = 1'b0; s_tap_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_abort: busy got %b expected 0", busy); end
   endtask

`ifdef TAPLOAD_CHECKSUM_EN
   task automatic test_checksum();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL csum_clear: got %h expected 0", checksum); end
      for (int k = 1; k <= 16; k++) feed_tap(32'(k));
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL csum_done: got %b expected 1", done); end
      checks++; if (checksum !== 32'h0000_0010) begin errors++; $display("FAIL csum_seq: got %h expected 00000010", checksum); end
      s_tap_valid = 1'b0;
      tick();
      checks++; if (checksum !== 32'h0000_0010) begin errors++; $display("FAIL csum_hold: got %h expected 00000010", checksum); end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) feed_tap(32'd0);
      checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL csum_zero: got %h expected 0", checksum); end
      s_tap_valid = 1'b0;
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_load();
      test_reset_mid_hold();
      test_stall();
      test_abort();
      test_back_to_back();
`ifdef TAPLOAD_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
